// File: rtl/cic_tdm_sched.sv
// cic_tdm_sched: round-robin TDM integrate-and-dump (single-stage CIC) decimator.
// CH input channels share one adder. Each channel keeps its own partial sum and
// phase count. Each finished sum goes to a single-entry valid/ready output register.
module cic_tdm_sched #(
  parameter int CH   = 4,
  parameter int DW   = 10,
  parameter int DECW = 4,
  parameter int OW   = DW + DECW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [DECW-1:0]        cfg_dec,
  output logic                   cfg_err,
  output logic [DECW-1:0]        dec_cur,
  output logic                   busy,
  input  logic [CH-1:0]          din_valid,
  input  logic [CH*DW-1:0]       din,
  output logic [CH-1:0]          din_ready,
  output logic                   dout_valid,
  output logic [OW-1:0]          dout,
  output logic [$clog2(CH)-1:0]  dout_ch,
  input  logic                   dout_ready
);

  localparam int CW = $clog2(CH);

  logic signed [OW-1:0] acc_q [CH];
  logic signed [OW-1:0] acc_d [CH];
  logic [DECW-1:0]      cnt_q [CH];
  logic [DECW-1:0]      cnt_d [CH];
  logic [CW-1:0]        ptr_q, ptr_d;
  logic signed [OW-1:0] dout_q, dout_d;
  logic [CW-1:0]        dout_ch_q, dout_ch_d;
  logic                 dout_valid_q, dout_valid_d;
  logic [DECW-1:0]      dec_cur_q, dec_cur_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 can_go;
  logic                 gnt_found;
  logic [CW-1:0]        gnt;
  logic                 xfer;
  logic                 dump;
  logic                 busy_w;
  logic                 cfg_ok;
  logic [DW-1:0]        samp;
  logic signed [OW-1:0] sext;

  // Round-robin grant: first valid channel searching upward from ptr+1 with wrap.
  // Grant is suppressed while reset is held so din_ready reads zero during reset.
  always_comb begin
    can_go    = (!dout_valid_q || dout_ready) && !rst;
    gnt_found = 1'b0;
    gnt       = ptr_q;
    for (int unsigned i = 1; i <= CH; i++) begin
      if (!gnt_found && din_valid[ptr_q + CW'(i)]) begin
        gnt_found = 1'b1;
        gnt       = ptr_q + CW'(i);
      end
    end
    xfer      = gnt_found && can_go;
    din_ready = '0;
    if (xfer) din_ready[gnt] = 1'b1;
  end

  // Accumulator update, dump into output register, and config acceptance.
  always_comb begin
    samp   = din[int'(gnt)*DW +: DW];
    sext   = {{(OW-DW){samp[DW-1]}}, samp};
    dump   = xfer && (cnt_q[gnt] == dec_cur_q - DECW'(1));
    busy_w = dout_valid_q;
    for (int unsigned k = 0; k < CH; k++) begin
      if (cnt_q[k] != '0) busy_w = 1'b1;
    end

    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = dout_valid_q && !dout_ready;
    if (xfer) begin
      ptr_d = gnt;
      if (dump) begin
        dout_d       = acc_q[gnt] + sext;
        dout_ch_d    = gnt;
        dout_valid_d = 1'b1;
        acc_d[gnt]   = '0;
        cnt_d[gnt]   = '0;
      end else begin
        acc_d[gnt] = acc_q[gnt] + sext;
        cnt_d[gnt] = cnt_q[gnt] + DECW'(1);
      end
    end

    cfg_ok    = cfg_we && !busy_w && !xfer;
    cfg_err_d = cfg_we && !cfg_ok;
    dec_cur_d = dec_cur_q;
    if (cfg_ok) dec_cur_d = (cfg_dec == '0) ? DECW'(1) : cfg_dec;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '{default: '0};
      cnt_q        <= '{default: '0};
      ptr_q        <= CW'(CH - 1);
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      dec_cur_q    <= DECW'(5);
      cfg_err_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      dec_cur_q    <= dec_cur_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg_err    = cfg_err_q;
  assign dec_cur    = dec_cur_q;
  assign busy       = busy_w;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;

endmodule

// File: tb/tb_cic_tdm_sched.sv
// tb_cic_tdm_sched: directed and randomized checks of cic_tdm_sched against a
// per-channel running-sum reference model.
module tb_cic_tdm_sched;

  localparam int CH   = 4;
  localparam int DW   = 10;
  localparam int DECW = 4;
  localparam int OW   = DW + DECW;
  localparam int CW   = 2;

  logic                clk;
  logic                rst;
  logic                cfg_we;
  logic [DECW-1:0]     cfg_dec;
  logic                cfg_err;
  logic [DECW-1:0]     dec_cur;
  logic                busy;
  logic [CH-1:0]       din_valid;
  logic [CH*DW-1:0]    din;
  logic [CH-1:0]       din_ready;
  logic                dout_valid;
  logic [OW-1:0]       dout;
  logic [CW-1:0]       dout_ch;
  logic                dout_ready;

  cic_tdm_sched #(.CH(CH), .DW(DW), .DECW(DECW), .OW(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_dec    (cfg_dec),
    .cfg_err    (cfg_err),
    .dec_cur    (dec_cur),
    .busy       (busy),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // stimulus state
  logic [CH-1:0] v;
  int            smp [CH];
  logic          dr;
  logic          we;
  int            cdec;

  // reference model: running sums and sample counts per channel
  int m_acc [CH];
  int m_cnt [CH];
  int m_ptr;
  int m_dv;
  int m_dout;
  int m_dch;
  int m_dec;
  int m_err;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int m_busy();
    int b = m_dv;
    for (int k = 0; k < CH; k++) if (m_cnt[k] != 0) b = 1;
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
    end
    m_ptr = CH - 1; m_dv = 0; m_dout = 0; m_dch = 0; m_dec = 5; m_err = 0;
  endtask

  task automatic check_outputs();
    check("dout_valid", int'(dout_valid), m_dv);
    check("dout", int'($signed(dout)), m_dout);
    check("dout_ch", int'(dout_ch), m_dch);
    check("dec_cur", int'(dec_cur), m_dec);
    check("cfg_err", int'(cfg_err), m_err);
    check("busy", int'(busy), m_busy());
  endtask

  // Apply inputs, check the grant, advance the model, clock, check registers.
  task automatic cycle();
    int g;
    int go;
    int cfg_ok;
    int s;
    for (int k = 0; k < CH; k++) din[k*DW +: DW] = DW'(smp[k]);
    din_valid  = v;
    dout_ready = dr;
    cfg_we     = we;
    cfg_dec    = DECW'(cdec);
    #1;
    go = (m_dv == 0) || dr;
    g  = -1;
    if (go) begin
      for (int i = 1; i <= CH; i++) begin
        int c = (m_ptr + i) % CH;
        if (v[c] && g < 0) g = c;
      end
    end
    check("din_ready", int'(din_ready), (g < 0) ? 0 : (1 << g));
    cfg_ok = we && !m_busy() && (g < 0);
    m_err  = we && !cfg_ok;
    m_dv   = m_dv && !dr;
    if (g >= 0) begin
      m_ptr = g;
      s = smp[g];
      if (m_cnt[g] == m_dec - 1) begin
        m_dout = m_acc[g] + s;
        m_dch  = g;
        m_dv   = 1;
        m_acc[g] = 0;
        m_cnt[g] = 0;
      end else begin
        m_acc[g] += s;
        m_cnt[g] += 1;
      end
    end
    if (cfg_ok) m_dec = (cdec == 0) ? 1 : cdec;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    v = '0; dr = 1'b1; we = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send(input int ch, input int val, input int n);
    v = '0; v[ch] = 1'b1; smp[ch] = val; dr = 1'b1; we = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic cfg_write(input int val);
    v = '0; dr = 1'b1; we = 1'b1; cdec = val;
    cycle();
    we = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    v = '1;
    din_valid = v;
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_din_ready", int'(din_ready), 0);
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; v = '1; dr = 1'b1; we = 1'b0; cdec = 0;
    for (int k = 0; k < CH; k++) smp[k] = 0;
    din_valid = v; din = '0; dout_ready = 1'b1; cfg_we = 1'b0; cfg_dec = '0;
    model_reset();
    #12;
    check("reset_din_ready", int'(din_ready), 0);
    check_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // single channel, default factor 5
    v = 4'b0001; dr = 1'b1;
    for (int i = 1; i <= 5; i++) begin smp[0] = i; cycle(); end
    check("sum_1to5", int'($signed(dout)), 15);
    check("sum_1to5_valid", int'(dout_valid), 1);
    send(0, -512, 5);
    check("sum_neg512x5", int'($signed(dout)), -2560);
    idle(1);

    // all channels valid every cycle, constant k+1
    v = '1; dr = 1'b1; we = 1'b0;
    for (int k = 0; k < CH; k++) smp[k] = k + 1;
    repeat (20) begin
      cycle();
      if (dout_valid) check("rr_sum", int'($signed(dout)), 5 * (int'(dout_ch) + 1));
    end
    idle(2);

    // backpressure and back-to-back refill
    v = '1; dr = 1'b0;
    repeat (25) cycle();
    dr = 1'b1; cycle();
    dr = 1'b0; repeat (3) cycle();
    dr = 1'b1; repeat (10) cycle();
    async_reset();

    // config rejected while busy, accepted when idle
    send(1, 10, 2);
    cfg_write(3);
    check("cfg_busy_err", int'(cfg_err), 1);
    check("cfg_busy_dec", int'(dec_cur), 5);
    send(1, 10, 3);
    check("ch1_sum", int'($signed(dout)), 50);
    idle(1);
    cfg_write(3);
    check("cfg_ok_dec", int'(dec_cur), 3);
    send(2, 100, 3);
    check("sum_100x3", int'($signed(dout)), 300);
    idle(1);
    cfg_write(0);
    check("cfg_zero_dec", int'(dec_cur), 1);
    foreach (smp[k]) smp[k] = 0;
    send(3, -512, 1); check("pass_neg", int'($signed(dout)), -512);
    send(3, 511, 1);  check("pass_pos", int'($signed(dout)), 511);
    send(0, -1, 1);   check("pass_m1", int'($signed(dout)), -1);
    idle(1);

    // extreme values at factor 15
    cfg_write(15);
    send(0, -512, 15);
    check("min_x15", int'($signed(dout)), -7680);
    idle(1);
    send(1, 511, 15);
    check("max_x15", int'($signed(dout)), 7665);
    idle(1);

    // reset with ch2 partly accumulated
    send(2, 7, 3);
    async_reset();
    send(2, 7, 4);
    check("post_rst_no_dump", int'(dout_valid), 0);
    send(2, 7, 1);
    check("post_rst_sum", int'($signed(dout)), 35);
    idle(1);

    // randomized traffic, backpressure and config attempts
    for (int i = 0; i < 1500; i++) begin
      v    = CH'($urandom);
      for (int k = 0; k < CH; k++) smp[k] = int'($urandom_range(0, 1023)) - 512;
      dr   = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 15) == 0);
      cdec = int'($urandom_range(0, 15));
      if (i % 250 == 249) begin
        v = '0; we = 1'b0;
      end
      cycle();
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
